// File: rtl/bcd_multidigit_counter_if.sv
// Control/status bundle for the multi-digit BCD counter.
// master drives the controls, slave is the counter itself.
interface bcd_multidigit_counter_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W = 4 * DIGITS;

  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         up_dn;
  logic [W-1:0] cnt;
  logic         tc;
  logic         ovf;
  logic         load_err;

  modport master (
    output clr, load, load_val, en, up_dn,
    input  cnt, tc, ovf, load_err
  );

  modport slave (
    input  clr, load, load_val, en, up_dn,
    output cnt, tc, ovf, load_err
  );
endinterface

// File: rtl/bcd_multidigit_counter.sv
// Parametrised multi-digit BCD up/down counter with clear, load, wrap or
// saturate at the range ends, and a combinational terminal count for chaining.
module bcd_multidigit_counter #(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  bcd_multidigit_counter_if.slave   bus
);
  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] step_val;
  logic         at_end;
  logic [W-1:0] load_clean;
  logic         load_bad;
  logic         tc_c;

  // One count step in the current direction. The carry/borrow chain runs from
  // digit 0 upward; an illegal nibble counts as 9 and steps to 0 either way.
  always_comb begin : step_calc
    logic       chain;
    logic [3:0] dig;
    chain    = 1'b1;
    dig      = 4'd0;
    step_val = cnt_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      dig = cnt_q[4*k +: 4];
      if (bus.up_dn) begin
        if (chain) step_val[4*k +: 4] = (dig >= 4'd9) ? 4'd0 : dig + 4'd1;
        chain = chain & (dig >= 4'd9);
      end else begin
        if (chain) step_val[4*k +: 4] = (dig == 4'd0) ? 4'd9 :
                                        (dig >  4'd9) ? 4'd0 : dig - 4'd1;
        chain = chain & (dig == 4'd0);
      end
    end
    // Chain still set after the last digit: counter sits at the range end.
    at_end = chain;
  end

  // Illegal nibbles in the load value load as 0 and flag an error.
  always_comb begin : load_check
    load_clean = bus.load_val;
    load_bad   = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bus.load_val[4*k +: 4] > 4'd9) begin
        load_clean[4*k +: 4] = 4'd0;
        load_bad             = 1'b1;
      end
    end
  end

  assign tc_c = bus.en & ~bus.clr & ~bus.load & at_end;

  // Next-state selection: clr > load > en > hold.
  always_comb begin : next_state
    cnt_d      = cnt_q;
    ovf_d      = 1'b0;
    load_err_d = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.load) begin
      cnt_d      = load_clean;
      load_err_d = load_bad;
    end else if (bus.en) begin
      ovf_d = at_end;
      if (WRAP || !at_end) cnt_d = step_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) begin
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.tc       = tc_c;
  assign bus.ovf      = ovf_q;
  assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_multidigit_counter.sv
// Bench for bcd_multidigit_counter: a wrapping and a saturating 2-digit counter
// plus a chained pair of 1-digit counters, all fed the same stimulus.
module tb_bcd_multidigit_counter;
  logic       clk;
  logic       rst;
  logic       clr_i, load_i, en_i, up_i;
  logic [7:0] lv_i;

  int total = 0;
  int bad   = 0;
  int mw    = 0;
  int ms    = 0;

  typedef struct packed {
    logic [7:0] cnt_w; logic ovf_w; logic lerr_w; logic tc_w;
    logic [7:0] cnt_s; logic ovf_s; logic lerr_s; logic tc_s;
    logic [7:0] cnt_c; logic ovf_c; logic tc_c;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];

  bcd_multidigit_counter_if #(.DIGITS(2)) bw();
  bcd_multidigit_counter_if #(.DIGITS(2)) bs();
  bcd_multidigit_counter_if #(.DIGITS(1)) bl();
  bcd_multidigit_counter_if #(.DIGITS(1)) bh();

  assign bw.clr = clr_i; assign bw.load = load_i; assign bw.load_val = lv_i;
  assign bw.en  = en_i;  assign bw.up_dn = up_i;
  assign bs.clr = clr_i; assign bs.load = load_i; assign bs.load_val = lv_i;
  assign bs.en  = en_i;  assign bs.up_dn = up_i;
  assign bl.clr = clr_i; assign bl.load = load_i; assign bl.load_val = lv_i[3:0];
  assign bl.en  = en_i;  assign bl.up_dn = up_i;
  assign bh.clr = clr_i; assign bh.load = load_i; assign bh.load_val = lv_i[7:4];
  assign bh.en  = bl.tc; assign bh.up_dn = bl.up_dn;

  bcd_multidigit_counter #(.DIGITS(2), .WRAP(1'b1)) dut_w  (.clk(clk), .rst(rst), .bus(bw));
  bcd_multidigit_counter #(.DIGITS(2), .WRAP(1'b0)) dut_s  (.clk(clk), .rst(rst), .bus(bs));
  bcd_multidigit_counter #(.DIGITS(1), .WRAP(1'b1)) dut_lo (.clk(clk), .rst(rst), .bus(bl));
  bcd_multidigit_counter #(.DIGITS(1), .WRAP(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(bh));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] to_bcd(input int m);
    logic [3:0] t, o;
    t = 4'(m / 10);
    o = 4'(m % 10);
    return {t, o};
  endfunction

  // Drive one cycle, predict it with a decimal model, record expected and observed.
  task automatic step(input logic c, input logic l, input logic [7:0] lv,
                      input logic e, input logic u);
    snap_t ex, ob;
    logic [3:0] hn, ln;
    logic tw, ts;
    clr_i = c; load_i = l; lv_i = lv; en_i = e; up_i = u;
    tw = e & ~c & ~l & (u ? (mw == 99) : (mw == 0));
    ts = e & ~c & ~l & (u ? (ms == 99) : (ms == 0));
    ex = '0;
    ex.tc_w = tw; ex.tc_s = ts; ex.tc_c = tw;
    if (c) begin
      mw = 0; ms = 0;
    end else if (l) begin
      hn = lv[7:4]; ln = lv[3:0];
      ex.lerr_w = (hn > 4'd9) || (ln > 4'd9);
      ex.lerr_s = ex.lerr_w;
      if (hn > 4'd9) hn = 4'd0;
      if (ln > 4'd9) ln = 4'd0;
      mw = int'(hn) * 10 + int'(ln);
      ms = mw;
    end else if (e) begin
      ex.ovf_w = tw; ex.ovf_s = ts; ex.ovf_c = tw;
      if (tw) mw = u ? 0 : 99;
      else    mw = u ? mw + 1 : mw - 1;
      if (!ts) ms = u ? ms + 1 : ms - 1;
    end
    ex.cnt_w = to_bcd(mw); ex.cnt_s = to_bcd(ms); ex.cnt_c = to_bcd(mw);
    exp_q.push_back(ex);
    #1;
    ob = '0;
    ob.tc_w = bw.tc; ob.tc_s = bs.tc; ob.tc_c = bh.tc;
    @(posedge clk);
    #1;
    ob.cnt_w = bw.cnt; ob.ovf_w = bw.ovf; ob.lerr_w = bw.load_err;
    ob.cnt_s = bs.cnt; ob.ovf_s = bs.ovf; ob.lerr_s = bs.load_err;
    ob.cnt_c = {bh.cnt, bl.cnt}; ob.ovf_c = bh.ovf;
    obs_q.push_back(ob);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clr_i = 1'b0; load_i = 1'b0; lv_i = 8'h00; en_i = 1'b0; up_i = 1'b1;
    mw = 0; ms = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bw.cnt, bw.ovf, bw.load_err, bs.cnt, bs.ovf, bs.load_err, bh.cnt, bl.cnt, bh.ovf} !== 29'd0) begin
      bad++;
      $display("FAIL reset_state got w=%h s=%h c=%h%h ovf=%b lerr=%b want all zero",
               bw.cnt, bs.cnt, bh.cnt, bl.cnt, bw.ovf, bw.load_err);
    end
    total++;
    if ({bw.tc, bs.tc} !== 2'b00) begin
      bad++;
      $display("FAIL reset_tc got %b want 00", {bw.tc, bs.tc});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_count_up();
    snap_t e, o;
    int i = 0, n_ovf = 0, n_tc = 0;
    for (int k = 0; k < 100; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_ovf += int'(o.ovf_w); n_tc += int'(o.tc_w);
      total++;
      if (o !== e) begin bad++; $display("FAIL count_up[%0d] got=%h want=%h", i, o, e); end
      i++;
    end
    total++;
    if (o.cnt_w !== 8'h00 || n_ovf != 1 || n_tc != 1) begin
      bad++;
      $display("FAIL count_up_wrap got cnt=%h ovf_pulses=%0d tc_cycles=%0d want 00/1/1", o.cnt_w, n_ovf, n_tc);
    end
  endtask

  task automatic test_count_down();
    snap_t e, o;
    int i = 0, n_ovf = 0;
    step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_ovf += int'(o.ovf_w);
      total++;
      if (o !== e) begin bad++; $display("FAIL count_down[%0d] got=%h want=%h", i, o, e); end
      i++;
    end
    total++;
    if (o.cnt_w !== 8'h98 || n_ovf != 1) begin
      bad++;
      $display("FAIL count_down_wrap got cnt=%h ovf_pulses=%0d want 98/1", o.cnt_w, n_ovf);
    end
  endtask

  task automatic test_saturate();
    snap_t e, o;
    int i = 0, n_ovf = 0;
    step(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (i >= 1 && i <= 3 && o.cnt_s === 8'h99) n_ovf += int'(o.ovf_s);
      total++;
      if (o !== e) begin bad++; $display("FAIL saturate[%0d] got=%h want=%h", i, o, e); end
      i++;
    end
    total++;
    if (n_ovf != 3 || o.cnt_s !== 8'h98 || o.ovf_s !== 1'b0) begin
      bad++;
      $display("FAIL saturate_hold got held_ovf=%0d cnt=%h ovf=%b want 3/98/0", n_ovf, o.cnt_s, o.ovf_s);
    end
  endtask

  task automatic test_load_err();
    snap_t e, o, first;
    int i = 0;
    step(1'b0, 1'b1, 8'h3A, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h72, 1'b0, 1'b0);
    first = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (i == 0) first = o;
      total++;
      if (o !== e) begin bad++; $display("FAIL load_err[%0d] got=%h want=%h", i, o, e); end
      i++;
    end
    total++;
    if (first.cnt_w !== 8'h30 || first.lerr_w !== 1'b1) begin
      bad++;
      $display("FAIL load_3A got cnt=%h load_err=%b want 30/1", first.cnt_w, first.lerr_w);
    end
  endtask

  task automatic test_mid_reset();
    snap_t e, o;
    int i = 0;
    step(1'b0, 1'b1, 8'h40, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL mid_reset_pre[%0d] got=%h want=%h", i, o, e); end
      i++;
    end
    #3;
    rst = 1'b0;
    #1;
    total++;
    if ({bw.cnt, bs.cnt, bh.cnt, bl.cnt} !== 24'h0) begin
      bad++;
      $display("FAIL async_reset got w=%h s=%h c=%h%h want 00", bw.cnt, bs.cnt, bh.cnt, bl.cnt);
    end
    @(posedge clk);
    #1;
    total++;
    if ({bw.cnt, bw.ovf, bs.cnt} !== 17'h0) begin
      bad++;
      $display("FAIL reset_held got w=%h ovf=%b s=%h want 00/0/00", bw.cnt, bw.ovf, bs.cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    mw = 0; ms = 0;
    i = 0;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL mid_reset_post[%0d] got=%h want=%h", i, o, e); end
      i++;
    end
  endtask

  task automatic test_chain();
    snap_t e, o;
    int i = 0, n_ovf = 0;
    step(1'b0, 1'b1, 8'h95, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_ovf += int'(o.ovf_c);
      total++;
      if (o !== e) begin bad++; $display("FAIL chain[%0d] got=%h want=%h", i, o, e); end
      i++;
    end
    total++;
    if (o.cnt_c !== 8'h98 || n_ovf != 2) begin
      bad++;
      $display("FAIL chain_end got cnt=%h ovf_pulses=%0d want 98/2", o.cnt_c, n_ovf);
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    int i = 0;
    step(1'b0, 1'b1, 8'h50, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'(k % 2));
    for (int k = 0; k < 60; k++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL back_to_back[%0d] got=%h want=%h", i, o, e); end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load_err();
    test_mid_reset();
    test_chain();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
